// File: rtl/pred_box_pkg.sv
// Shared box record, byte layout constants and field decode helper
// for the prediction box overlay.
package pred_box_pkg;

    localparam int BYTES_PER_BOX = 8;
    localparam logic [15:0] EMPTY_MARK = 16'hFFFF;

    localparam int P_XMIN_HI = 0;
    localparam int P_XMIN_LO = 1;
    localparam int P_YMIN_HI = 2;
    localparam int P_YMIN_LO = 3;
    localparam int P_XMAX_HI = 4;
    localparam int P_XMAX_LO = 5;
    localparam int P_YMAX_HI = 6;
    localparam int P_YMAX_LO = 7;

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } col_state_t;

    typedef struct packed {
        logic [9:0] x_min;
        logic [9:0] y_min;
        logic [9:0] x_max;
        logic [9:0] y_max;
        logic       valid;
    } box_t;

    function automatic logic [9:0] clamp10(
        input logic [15:0] raw,
        input logic [9:0]  lim
    );
        return (raw > {6'd0, lim}) ? lim : raw[9:0];
    endfunction

    // The empty marker is judged on the raw field, ordering after clamping.
    function automatic box_t decode_box(
        input logic [15:0] xmin_raw,
        input logic [15:0] ymin_raw,
        input logic [15:0] xmax_raw,
        input logic [15:0] ymax_raw,
        input logic [9:0]  h_max,
        input logic [9:0]  v_max
    );
        box_t bx;
        bx.x_min = clamp10(xmin_raw, h_max);
        bx.y_min = clamp10(ymin_raw, v_max);
        bx.x_max = clamp10(xmax_raw, h_max);
        bx.y_max = clamp10(ymax_raw, v_max);
        bx.valid = (xmin_raw != EMPTY_MARK) &&
                   (bx.x_min <= bx.x_max) &&
                   (bx.y_min <= bx.y_max);
        return bx;
    endfunction

endpackage

// File: rtl/pred_box_overlay_hit.sv
// Combinational per-box border (or fill) test for one pixel query.
// Fill mode is selected by PRED_BOX_OVERLAY_FILL_EN.
module pred_box_hit
    import pred_box_pkg::*;
#(
    parameter int LINE_W = 2
) (
    input  box_t       i_box,
    input  logic [9:0] i_h,
    input  logic [9:0] i_v,
    output logic       o_hit
);

    logic [10:0] w_h;
    logic [10:0] w_v;
    logic [10:0] w_xmin;
    logic [10:0] w_ymin;
    logic [10:0] w_xmax;
    logic [10:0] w_ymax;
    logic        w_in_rng;

    assign w_h    = {1'b0, i_h};
    assign w_v    = {1'b0, i_v};
    assign w_xmin = {1'b0, i_box.x_min};
    assign w_ymin = {1'b0, i_box.y_min};
    assign w_xmax = {1'b0, i_box.x_max};
    assign w_ymax = {1'b0, i_box.y_max};

    assign w_in_rng = i_box.valid &&
                      (w_h >= w_xmin) && (w_h <= w_xmax) &&
                      (w_v >= w_ymin) && (w_v <= w_ymax);

`ifdef PRED_BOX_OVERLAY_FILL_EN
    assign o_hit = w_in_rng;
`else
    localparam logic [10:0] LW = 11'(LINE_W);

    logic w_border;

    // Far edges use h+LW > max so a small max cannot underflow.
    assign w_border = (w_h < w_xmin + LW) ||
                      (w_h + LW > w_xmax) ||
                      (w_v < w_ymin + LW) ||
                      (w_v + LW > w_ymax);

    assign o_hit = w_in_rng && w_border;
`endif

endmodule

// File: rtl/pred_box_overlay.sv
// Prediction byte assembler with double-buffered box table and pixel query.
// Define PRED_BOX_OVERLAY_FILL_EN to fill box interiors instead of borders.
module pred_box_overlay
    import pred_box_pkg::*;
#(
    parameter int N_BOX  = 15,
    parameter int H_MAX  = 639,
    parameter int V_MAX  = 479,
    parameter int LINE_W = 2
) (
    input  logic       avm_clk,
    input  logic       avm_rst,
    input  logic [7:0] i_readdata,
    input  logic       i_readdata_valid,
    input  logic       i_start_send,
    input  logic       i_query_valid,
    input  logic [9:0] i_h,
    input  logic [9:0] i_v,
    output logic       o_hit,
    output logic       o_hit_valid,
    output logic       o_frame_done,
    output logic [3:0] o_box_count
);

    localparam int N_BYTES = N_BOX * BYTES_PER_BOX;
    localparam int CW      = $clog2(N_BYTES);
    localparam logic [CW-1:0] LAST = CW'(N_BYTES - 1);

    col_state_t    r_state;
    logic [CW-1:0] r_byte_cnt;
    logic [7:0]    r_shadow [N_BYTES];
    box_t          r_active [N_BOX];
    logic          r_frame_done;
    logic [3:0]    r_box_count;
    logic          r_hit;
    logic          r_hit_valid;

    logic [7:0]    w_merged [N_BYTES];
    box_t          w_next   [N_BOX];
    logic [3:0]    w_next_cnt;
    logic [CW-1:0] w_wr_idx;
    logic          w_commit;
    logic [N_BOX-1:0] w_box_hit;

    assign w_wr_idx = (r_state == ST_IDLE) ? '0 : r_byte_cnt;
    assign w_commit = i_readdata_valid && !i_start_send &&
                      (w_wr_idx == LAST);

    // Next table: shadow with the final byte of the frame merged in.
    always_comb begin
        w_merged = r_shadow;
        w_merged[N_BYTES-1] = i_readdata;
        w_next_cnt = '0;
        for (int b = 0; b < N_BOX; b++) begin
            w_next[b] = decode_box(
                {w_merged[b*BYTES_PER_BOX + P_XMIN_HI],
                 w_merged[b*BYTES_PER_BOX + P_XMIN_LO]},
                {w_merged[b*BYTES_PER_BOX + P_YMIN_HI],
                 w_merged[b*BYTES_PER_BOX + P_YMIN_LO]},
                {w_merged[b*BYTES_PER_BOX + P_XMAX_HI],
                 w_merged[b*BYTES_PER_BOX + P_XMAX_LO]},
                {w_merged[b*BYTES_PER_BOX + P_YMAX_HI],
                 w_merged[b*BYTES_PER_BOX + P_YMAX_LO]},
                10'(H_MAX), 10'(V_MAX));
            w_next_cnt = w_next_cnt + 4'(w_next[b].valid);
        end
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_state      <= ST_IDLE;
            r_byte_cnt   <= '0;
            r_frame_done <= 1'b0;
            r_box_count  <= '0;
            for (int k = 0; k < N_BYTES; k++) begin
                r_shadow[k] <= '0;
            end
            for (int b = 0; b < N_BOX; b++) begin
                r_active[b] <= '0;
            end
        end else begin
            r_frame_done <= 1'b0;
            if (i_start_send) begin
                // Resync: the byte arriving alongside is byte 0.
                if (i_readdata_valid) begin
                    r_shadow[0] <= i_readdata;
                    r_byte_cnt  <= CW'(1);
                    r_state     <= ST_COLLECT;
                end else begin
                    r_byte_cnt  <= '0;
                    r_state     <= ST_IDLE;
                end
            end else if (i_readdata_valid) begin
                r_shadow[w_wr_idx] <= i_readdata;
                if (w_commit) begin
                    r_byte_cnt   <= '0;
                    r_state      <= ST_IDLE;
                    r_frame_done <= 1'b1;
                    r_box_count  <= w_next_cnt;
                    for (int b = 0; b < N_BOX; b++) begin
                        r_active[b] <= w_next[b];
                    end
                end else begin
                    r_byte_cnt <= w_wr_idx + 1'b1;
                    r_state    <= ST_COLLECT;
                end
            end
        end
    end

    for (genvar g = 0; g < N_BOX; g++) begin : g_hit
        pred_box_hit #(
            .LINE_W(LINE_W)
        ) u_hit (
            .i_box(r_active[g]),
            .i_h  (i_h),
            .i_v  (i_v),
            .o_hit(w_box_hit[g])
        );
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_hit       <= 1'b0;
            r_hit_valid <= 1'b0;
        end else begin
            r_hit       <= i_query_valid && (|w_box_hit);
            r_hit_valid <= i_query_valid;
        end
    end

    assign o_hit        = r_hit;
    assign o_hit_valid  = r_hit_valid;
    assign o_frame_done = r_frame_done;
    assign o_box_count  = r_box_count;

endmodule

// File: tb/tb_pred_box_overlay.sv
// Directed scoreboard bench for pred_box_overlay.
module tb_pred_box_overlay;

    logic       avm_clk = 1'b0;
    logic       avm_rst = 1'b1;
    logic [7:0] i_readdata = '0;
    logic       i_readdata_valid = 1'b0;
    logic       i_start_send = 1'b0;
    logic       i_query_valid = 1'b0;
    logic [9:0] i_h = '0;
    logic [9:0] i_v = '0;
    logic       o_hit;
    logic       o_hit_valid;
    logic       o_frame_done;
    logic [3:0] o_box_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    logic [15:0] fr [15][4];
    logic        exp_q [$];

    pred_box_overlay dut (
        .avm_clk         (avm_clk),
        .avm_rst         (avm_rst),
        .i_readdata      (i_readdata),
        .i_readdata_valid(i_readdata_valid),
        .i_start_send    (i_start_send),
        .i_query_valid   (i_query_valid),
        .i_h             (i_h),
        .i_v             (i_v),
        .o_hit           (o_hit),
        .o_hit_valid     (o_hit_valid),
        .o_frame_done    (o_frame_done),
        .o_box_count     (o_box_count)
    );

    always #5 avm_clk = ~avm_clk;

    always @(negedge avm_clk) begin
        if (o_frame_done === 1'b1) n_done++;
    end

    task automatic tick();
        @(posedge avm_clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input int k);
        logic [15:0] f;
        f = fr[k / 8][(k % 8) / 2];
        return ((k % 2) == 0) ? f[15:8] : f[7:0];
    endfunction

    task automatic clear_frame();
        for (int b = 0; b < 15; b++) begin
            fr[b][0] = 16'hFFFF;
            fr[b][1] = 16'h0000;
            fr[b][2] = 16'h0000;
            fr[b][3] = 16'h0000;
        end
    endtask

    task automatic set_box(input int b, input int x0, input int y0,
                           input int x1, input int y1);
        fr[b][0] = 16'(x0);
        fr[b][1] = 16'(y0);
        fr[b][2] = 16'(x1);
        fr[b][3] = 16'(y1);
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            i_readdata       = get_byte(k);
            i_readdata_valid = 1'b1;
            tick();
        end
        i_readdata_valid = 1'b0;
    endtask

    task automatic query(input string tag, input int h, input int v,
                         input logic exp);
        logic e;
        i_h = 10'(h);
        i_v = 10'(v);
        i_query_valid = 1'b1;
        exp_q.push_back(exp);
        tick();
        i_query_valid = 1'b0;
        e = exp_q.pop_front();
        check({tag, "_vld"}, int'(o_hit_valid), 1);
        check(tag, int'(o_hit), int'(e));
    endtask

    task automatic send_full_frame(input string tag, input int exp_cnt,
                                   input bit with_start);
        int d0;
        d0 = n_done;
        if (with_start) begin
            i_start_send     = 1'b1;
            i_readdata       = get_byte(0);
            i_readdata_valid = 1'b1;
            tick();
            i_start_send     = 1'b0;
            send_range(1, 118);
        end else begin
            send_range(0, 118);
        end
        check({tag, "_no_early_done"}, n_done, d0);
        send_range(119, 119);
        check({tag, "_done_pulse"}, int'(o_frame_done), 1);
        check({tag, "_box_count"}, int'(o_box_count), exp_cnt);
        tick();
        check({tag, "_done_clear"}, int'(o_frame_done), 0);
        check({tag, "_done_once"}, n_done, d0 + 1);
    endtask

    initial begin
        logic e;
        #2;
        check("rst_hit", int'(o_hit), 0);
        check("rst_hit_valid", int'(o_hit_valid), 0);
        check("rst_frame_done", int'(o_frame_done), 0);
        check("rst_box_count", int'(o_box_count), 0);
        tick();
        tick();
        avm_rst = 1'b0;
        tick();
        query("q_reset_00", 0, 0, 1'b0);
        check("reset_count", int'(o_box_count), 0);

        // Frame A: single border box
        clear_frame();
        set_box(0, 100, 50, 200, 150);
        send_full_frame("frameA", 1, 1'b0);
        query("qA_100_80", 100, 80, 1'b1);
        query("qA_101_80", 101, 80, 1'b1);
        query("qA_102_80", 102, 80, 1'b0);
        query("qA_150_149", 150, 149, 1'b1);
`ifdef PRED_BOX_OVERLAY_FILL_EN
        query("qA_150_100", 150, 100, 1'b1);
`else
        query("qA_150_100", 150, 100, 1'b0);
`endif
        query("qA_201_80", 201, 80, 1'b0);
        query("qA_200_150", 200, 150, 1'b1);

        // Partial frame, resync, then a clean frame
        clear_frame();
        set_box(0, 10, 10, 20, 20);
        set_box(1, 30, 30, 40, 40);
        send_range(0, 59);
        i_start_send = 1'b1;
        tick();
        i_start_send = 1'b0;
        clear_frame();
        set_box(0, 300, 300, 400, 400);
        set_box(3, 0, 0, 5, 5);
        send_full_frame("resync", 2, 1'b0);
        query("qR_300_300", 300, 300, 1'b1);
        query("qR_100_80", 100, 80, 1'b0);
        query("qR_10_10", 10, 10, 1'b0);
        query("qR_0_3", 0, 3, 1'b1);

        // Clamp and invalid box; start_send with byte 0 in the same cycle
        clear_frame();
        set_box(0, 600, 400, 16'h0400, 16'h0300);
        set_box(1, 300, 0, 200, 50);
        send_full_frame("clamp", 1, 1'b1);
        query("qC_639_479", 639, 479, 1'b1);
        query("qC_620_479", 620, 479, 1'b1);
        query("qC_250_10", 250, 10, 1'b0);
        query("qC_640_479", 640, 479, 1'b0);

        // Query in the commit cycle sees the old table
        clear_frame();
        set_box(0, 100, 50, 200, 150);
        send_range(0, 118);
        i_readdata       = get_byte(119);
        i_readdata_valid = 1'b1;
        i_h = 10'd639;
        i_v = 10'd479;
        i_query_valid = 1'b1;
        exp_q.push_back(1'b1);
        tick();
        i_readdata_valid = 1'b0;
        i_query_valid    = 1'b0;
        e = exp_q.pop_front();
        check("commit_q_vld", int'(o_hit_valid), 1);
        check("commit_q_old", int'(o_hit), int'(e));
        check("commit_done", int'(o_frame_done), 1);
        query("commit_q_new", 639, 479, 1'b0);
        query("commit_q_new_box", 100, 80, 1'b1);

        // Reset mid-frame
        clear_frame();
        set_box(0, 400, 100, 500, 200);
        send_range(0, 29);
        avm_rst = 1'b1;
        #1;
        check("midrst_count", int'(o_box_count), 0);
        check("midrst_done", int'(o_frame_done), 0);
        tick();
        avm_rst = 1'b0;
        tick();
        query("midrst_q_old", 100, 80, 1'b0);
        send_full_frame("postrst", 1, 1'b0);
        query("postrst_q_400_150", 400, 150, 1'b1);
        query("postrst_q_100_80", 100, 80, 1'b0);
        query("idle_noquery_chk", 401, 101, 1'b1);
        tick();
        check("hit_valid_idle", int'(o_hit_valid), 0);
        check("hit_idle", int'(o_hit), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
